// File: rtl/md5_command_sequencer.sv
// md5_command_sequencer
//
// Drives the 32-bit command port of the MD5 brute-force core. On an accepted
// start it latches the target digest and character range, sends the fixed
// 12-word configuration sequence, then periodically polls the 64-bit
// candidate count (GET_LO, then GET_HI) until the core reports a match or the
// host aborts.
//
// Every word is presented for one SETUP cycle with the strobe low. The strobe
// is then high for STROBE_HIGH cycles and low for STROBE_LOW cycles. The final
// low cycle is the NEXT state, where status is captured and the next action
// is chosen.
//
// Ports
//   clk          in   single clock, posedge
//   reset        in   asynchronous active-high reset
//   start        in   begin a search (accepted in IDLE or DONE)
//   abort        in   stop a running search
//   target_hash  in   128-bit digest, A=[127:96] .. D=[31:0]
//   range_min    in   lowest printable byte
//   range_max    in   highest printable byte
//   matched      in   core match level (asynchronous)
//   status_word  in   core data output
//   cmd_data     out  command word to the core
//   cmd_strobe   out  core receive strobe (core acts on rising edge)
//   busy         out  search in progress
//   done         out  search finished (level)
//   found        out  finished because of a match
//   count        out  last complete 64-bit candidate count
//   count_valid  out  one-cycle pulse when count updates

module md5_command_sequencer #(
  parameter int STROBE_HIGH   = 2,
  parameter int STROBE_LOW    = 2,
  parameter int POLL_INTERVAL = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] target_hash,
  input  logic [7:0]   range_min,
  input  logic [7:0]   range_max,
  input  logic         matched,
  input  logic [31:0]  status_word,
  output logic [31:0]  cmd_data,
  output logic         cmd_strobe,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [63:0]  count,
  output logic         count_valid
);

  localparam logic [31:0] RESET_GEN = 32'h5230_0000;
  localparam logic [31:0] START_GEN = 32'h5230_0001;
  localparam logic [31:0] SET_A     = 32'h5230_1000;
  localparam logic [31:0] SET_B     = 32'h5230_1001;
  localparam logic [31:0] SET_C     = 32'h5230_1002;
  localparam logic [31:0] SET_D     = 32'h5230_1003;
  localparam logic [31:0] SET_RANGE = 32'h5230_2000;
  localparam logic [31:0] GET_LO    = 32'h5230_3000;
  localparam logic [31:0] GET_HI    = 32'h5230_3001;
  localparam logic [31:0] NOOP      = 32'h0000_0000;

  localparam logic [3:0] IDX_START_GEN = 4'd11;
  localparam logic [3:0] IDX_GET_LO    = 4'd12;
  localparam logic [3:0] IDX_GET_HI    = 4'd13;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STR_H,
    STR_L,
    NEXT,
    WAIT,
    DONE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_wordIdx;
  logic [31:0]   r_timer;
  logic [127:0]  r_hash;
  logic [7:0]    r_rangeMin;
  logic [7:0]    r_rangeMax;
  logic [31:0]   r_loShadow;
  logic          r_matchMeta;
  logic          r_matchSync;
  logic          r_abortPend;
  logic          r_aborting;
  logic          r_running;

  logic [3:0]    w_nextIdx;
  logic [31:0]   w_nextWord;

  // Maps a word index onto the command word it carries, using the latched
  // configuration so later input changes have no effect.
  function automatic logic [31:0] wordFor(
    input logic [3:0]   idx,
    input logic [127:0] hash,
    input logic [7:0]   rmin,
    input logic [7:0]   rmax
  );
    logic [31:0] w;
    w = NOOP;
    case (idx)
      4'd0:  w = RESET_GEN;
      4'd1:  w = SET_A;
      4'd2:  w = hash[127:96];
      4'd3:  w = SET_B;
      4'd4:  w = hash[95:64];
      4'd5:  w = SET_C;
      4'd6:  w = hash[63:32];
      4'd7:  w = SET_D;
      4'd8:  w = hash[31:0];
      4'd9:  w = SET_RANGE;
      4'd10: w = {16'h0000, rmax, rmin};
      4'd11: w = START_GEN;
      4'd12: w = GET_LO;
      4'd13: w = GET_HI;
      default: w = NOOP;
    endcase
    return w;
  endfunction

  assign w_nextIdx  = r_wordIdx + 4'd1;
  assign w_nextWord = wordFor(w_nextIdx, r_hash, r_rangeMin, r_rangeMax);

  // Two-flop synchronizer for the core's asynchronous match level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_matchMeta <= 1'b0;
      r_matchSync <= 1'b0;
    end else begin
      r_matchMeta <= matched;
      r_matchSync <= r_matchMeta;
    end
  end

  // Main sequencer. An abort seen while a word is in flight is remembered
  // and acted on only in NEXT, so the strobe is never cut short. The abort
  // branches are tested before the match branches, so abort wins a tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wordIdx   <= 4'd0;
      r_timer     <= 32'd0;
      r_hash      <= 128'd0;
      r_rangeMin  <= 8'd0;
      r_rangeMax  <= 8'd0;
      r_loShadow  <= 32'd0;
      r_abortPend <= 1'b0;
      r_aborting  <= 1'b0;
      r_running   <= 1'b0;
      cmd_data    <= 32'd0;
      cmd_strobe  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      count       <= 64'd0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (abort && busy && !r_aborting) begin
        r_abortPend <= 1'b1;
      end

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_hash      <= target_hash;
            r_rangeMin  <= range_min;
            r_rangeMax  <= range_max;
            r_wordIdx   <= 4'd0;
            r_running   <= 1'b0;
            r_aborting  <= 1'b0;
            r_abortPend <= 1'b0;
            cmd_data    <= RESET_GEN;
            busy        <= 1'b1;
            done        <= 1'b0;
            found       <= 1'b0;
            count       <= 64'd0;
            r_state     <= SETUP;
          end
        end

        SETUP: begin
          r_timer    <= 32'd0;
          cmd_strobe <= 1'b1;
          r_state    <= STR_H;
        end

        STR_H: begin
          if (r_timer == 32'(STROBE_HIGH - 1)) begin
            r_timer    <= 32'd0;
            cmd_strobe <= 1'b0;
            // NEXT supplies the last low cycle, so STR_L is skipped when
            // only one low cycle is wanted.
            r_state    <= (STROBE_LOW > 1) ? STR_L : NEXT;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end

        STR_L: begin
          if (r_timer >= 32'(STROBE_LOW - 2)) begin
            r_state <= NEXT;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end

        NEXT: begin
          r_timer <= 32'd0;
          if (r_aborting) begin
            r_aborting  <= 1'b0;
            r_abortPend <= 1'b0;
            r_running   <= 1'b0;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end else if (r_abortPend || abort) begin
            r_aborting  <= 1'b1;
            r_abortPend <= 1'b0;
            cmd_data    <= RESET_GEN;
            r_state     <= SETUP;
          end else if (r_running && r_matchSync) begin
            r_running <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            found     <= 1'b1;
            r_state   <= DONE;
          end else if (r_wordIdx == IDX_START_GEN) begin
            r_running <= 1'b1;
            r_state   <= WAIT;
          end else if (r_wordIdx == IDX_GET_LO) begin
            r_loShadow <= status_word;
            r_wordIdx  <= w_nextIdx;
            cmd_data   <= w_nextWord;
            r_state    <= SETUP;
          end else if (r_wordIdx == IDX_GET_HI) begin
            count       <= {status_word, r_loShadow};
            count_valid <= 1'b1;
            r_state     <= WAIT;
          end else begin
            r_wordIdx <= w_nextIdx;
            cmd_data  <= w_nextWord;
            r_state   <= SETUP;
          end
        end

        WAIT: begin
          if (abort || r_abortPend) begin
            r_aborting  <= 1'b1;
            r_abortPend <= 1'b0;
            cmd_data    <= RESET_GEN;
            r_state     <= SETUP;
          end else if (r_matchSync) begin
            r_running <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            found     <= 1'b1;
            r_state   <= DONE;
          end else if (r_timer == 32'(POLL_INTERVAL - 1)) begin
            r_timer   <= 32'd0;
            r_wordIdx <= IDX_GET_LO;
            cmd_data  <= GET_LO;
            r_state   <= SETUP;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
